regfile_dump: RTL and testbench
===============================

REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 32, meaning the number of register-file entries read out, range 2..32.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the register and output word width in bits.
REQ-003 The block SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  request to begin a dump, sampled on the rising clock edge.
REQ-006 The block SHALL have port busy  output  1  high from the cycle after start is accepted until done asserts.
REQ-007 The block SHALL have port done  output  1  single-cycle pulse when the dump completes.
REQ-008 The block SHALL have port rf_raddr  output  5  register-file read address.
REQ-009 The block SHALL have port rf_rdata  input  DATA_W  combinational register-file read data for rf_raddr.
REQ-010 The block SHALL have port out_valid  output  1  out_data holds a valid word.
REQ-011 The block SHALL have port out_ready  input  1  sink accepts the word when it is high together with out_valid.
REQ-012 The block SHALL have port out_data  output  DATA_W  registered dump word.
REQ-013 The block SHALL have port out_last  output  1  high with the final word of the dump.

Function
REQ-014 The FSM SHALL have the states IDLE, READ, SEND, CSUM and DONE, with IDLE after reset.
REQ-015 In IDLE, start=1 SHALL clear idx and the checksum and move to READ; start SHALL be ignored in every other state.
REQ-016 In READ, rf_raddr SHALL equal idx, and the block SHALL register rf_rdata into out_data, add it to the checksum (mod 2^DATA_W) and move to SEND.
REQ-017 In SEND, out_valid SHALL be 1, and out_data and out_last SHALL stay stable until out_valid and out_ready are both high.
REQ-018 On a SEND handshake with idx<NUM_REGS-1, the block SHALL increment idx and move to READ.
REQ-019 On a SEND handshake with idx=NUM_REGS-1, the block SHALL move to CSUM when the checksum feature is compiled in, and to DONE otherwise.
REQ-020 In DONE, done SHALL be 1 for exactly one cycle and the FSM SHALL then return to IDLE.
REQ-021 The first out_valid SHALL appear 2 cycles after start is sampled, and the peak rate SHALL be one word per 2 cycles.
REQ-022 out_last SHALL be high only on the final word: register NUM_REGS-1 when the checksum feature is compiled out, the checksum word when it is compiled in.
REQ-023 When idx is not being used, rf_raddr SHALL be 0 (IDLE, DONE, CSUM).
REQ-024 out_ready held low SHALL stall the dump indefinitely with no word lost or duplicated.

Reset
REQ-025 Asserting reset in any state SHALL immediately force IDLE with busy=0, done=0, out_valid=0, out_last=0, out_data=0, rf_raddr=0, idx=0 and checksum=0.
REQ-026 A dump interrupted by reset SHALL NOT resume, and the next start SHALL begin again at register 0.

Configuration
REQ-027 With macro REGDUMP_CHECKSUM_EN defined, the block SHALL present one extra word from CSUM: out_data = sum of all dumped words mod 2^DATA_W, with out_valid=1 and out_last=1, using the same hold rules as SEND; after that handshake the FSM SHALL move to DONE.
REQ-028 With REGDUMP_CHECKSUM_EN undefined, the CSUM state and checksum register SHALL be absent, and exactly NUM_REGS words SHALL be emitted.

Verification
REQ-029 The bench SHALL cover: register file data[i]=i, out_ready tied to 1, one start pulse -> words 0..31 in order, out_last only on 31, done pulses 1 cycle after the last handshake, 65 cycles total from start.
REQ-030 The bench SHALL cover: same setup with REGDUMP_CHECKSUM_EN defined -> 33 words, the last one 0x000001F0 with out_last=1.
REQ-031 The bench SHALL cover: out_ready low for 5 cycles on word 7 -> out_data holds 7 and out_valid stays 1 for the whole stall, and word 8 follows with no gap error.
REQ-032 The bench SHALL cover: start pulsed while busy (word 3) -> no restart, and the sequence continues 4,5,… unchanged.
REQ-033 The bench SHALL cover: reset asserted mid-cycle while SEND shows word 10 -> out_valid and busy drop asynchronously, and a new start dumps again from word 0.
REQ-034 The bench SHALL cover: NUM_REGS=4 with data {0,5,9,0xFFFFFFFF} and the checksum enabled -> checksum word 0x0000000D (wrap-around).

Source files
------------

// File: rtl/regfile_dump.sv
// Reads NUM_REGS register-file entries in order and streams them out over a valid/ready port.
// Define REGDUMP_CHECKSUM_EN to append a modular checksum word as the final (last) beat.
module regfile_dump #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [4:0]        rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

`ifdef REGDUMP_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, READ, SEND, CSUM, DONE} state_t;
    logic [DATA_W-1:0] csum;
`else
    typedef enum logic [2:0] {IDLE, READ, SEND, DONE} state_t;
`endif

    state_t     state, next_state;
    logic [4:0] idx;
    logic       at_last;

    assign at_last = (idx == LAST_IDX);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // All handshake states drive out_valid=1, so out_ready alone qualifies the transfer.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        rf_raddr   = '0;
        case (state)
            IDLE: begin
                if (start) next_state = READ;
            end
            READ: begin
                busy       = 1'b1;
                rf_raddr   = idx;
                next_state = SEND;
            end
            SEND: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                rf_raddr  = idx;
`ifdef REGDUMP_CHECKSUM_EN
                if (out_ready) next_state = at_last ? CSUM : READ;
`else
                out_last  = at_last;
                if (out_ready) next_state = at_last ? DONE : READ;
`endif
            end
`ifdef REGDUMP_CHECKSUM_EN
            CSUM: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = 1'b1;
                if (out_ready) next_state = DONE;
            end
`endif
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx      <= '0;
            out_data <= '0;
`ifdef REGDUMP_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx  <= '0;
`ifdef REGDUMP_CHECKSUM_EN
                        csum <= '0;
`endif
                    end
                end
                READ: begin
                    out_data <= rf_rdata;
`ifdef REGDUMP_CHECKSUM_EN
                    csum     <= csum + rf_rdata;
`endif
                end
                SEND: begin
                    if (out_ready) begin
                        if (!at_last) idx <= idx + 5'd1;
`ifdef REGDUMP_CHECKSUM_EN
                        // csum already includes the final word, added during its READ.
                        if (at_last) out_data <= csum;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: directed and random dumps scored against an
// expected word list built from the register-file contents (plus checksum when enabled).
`timescale 1ns/1ps
module tb_regfile_dump;

`ifdef REGDUMP_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset, start, start4, out_ready;
    logic        busy, done, out_valid, out_last;
    logic        busy4, done4, out_valid4, out_last4;
    logic [4:0]  rf_raddr, rf_raddr4;
    logic [31:0] rf_rdata, rf_rdata4, out_data, out_data4;
    logic [31:0] rf  [32];
    logic [31:0] rf4 [32];

    int          total = 0;
    int          bad   = 0;
    bit          sel4  = 1'b0;
    logic [31:0] last_word;

    logic        m_busy, m_done, m_valid, m_last;
    logic [4:0]  m_raddr;
    logic [31:0] m_data;

    always #5 clock = ~clock;

    assign rf_rdata  = rf[rf_raddr];
    assign rf_rdata4 = rf4[rf_raddr4];

    assign m_busy  = sel4 ? busy4      : busy;
    assign m_done  = sel4 ? done4      : done;
    assign m_valid = sel4 ? out_valid4 : out_valid;
    assign m_last  = sel4 ? out_last4  : out_last;
    assign m_raddr = sel4 ? rf_raddr4  : rf_raddr;
    assign m_data  = sel4 ? out_data4  : out_data;

    regfile_dump dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    regfile_dump #(.NUM_REGS(4), .DATA_W(32)) dut4 (
        .clock(clock), .reset(reset), .start(start4), .busy(busy4), .done(done4),
        .rf_raddr(rf_raddr4), .rf_rdata(rf_rdata4), .out_valid(out_valid4),
        .out_ready(out_ready), .out_data(out_data4), .out_last(out_last4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete dump on the selected instance. k counts rising edges after the one
    // that samples start; outputs are inspected on the falling edge that follows.
    task automatic run_dump(input string tag, input int stall_at, input int stall_len,
                            input int restart_at, input int reset_at, input bit rand_ready,
                            input int exp_done_k);
        logic [31:0] exp_q[$];
        logic [31:0] sum;
        int          nregs, len, n, k, hs_k, stall_left;
        bit          finished, fresh, in_stall, restarted;
        nregs = sel4 ? 4 : 32;
        sum   = '0;
        for (int i = 0; i < nregs; i++) begin
            logic [31:0] w;
            w = sel4 ? rf4[i] : rf[i];
            exp_q.push_back(w);
            sum += w;
        end
        if (CSUM_ON) exp_q.push_back(sum);
        len        = exp_q.size();
        n          = 0;
        hs_k       = -1;
        stall_left = stall_len;
        finished   = 1'b0;
        fresh      = 1'b1;
        in_stall   = 1'b0;
        restarted  = 1'b0;

        @(negedge clock);
        start     = !sel4;
        start4    = sel4;
        out_ready = 1'b1;
        @(negedge clock);
        for (k = 0; k < 2000 && !finished; k++) begin
            start  = 1'b0;
            start4 = 1'b0;
            if (in_stall) chk({tag, "_stall_valid"}, m_valid, 1);
            in_stall = 1'b0;
            if (m_done) begin
                chk({tag, "_done_gap"}, k, hs_k + 1);
                chk({tag, "_count"}, n, len);
                chk({tag, "_busy_at_done"}, m_busy, 0);
                if (exp_done_k >= 0) chk({tag, "_done_cycle"}, k, exp_done_k);
                @(negedge clock);
                chk({tag, "_done_pulse"}, m_done, 0);
                chk({tag, "_idle_busy"}, m_busy, 0);
                chk({tag, "_idle_valid"}, m_valid, 0);
                chk({tag, "_idle_raddr"}, m_raddr, 0);
                finished = 1'b1;
            end else begin
                chk({tag, "_busy"}, m_busy, 1);
                if (m_valid) begin
                    chk({tag, "_overrun"}, n < len, 1);
                    if (n < len) begin
                        chk({tag, "_data"}, m_data, exp_q[n]);
                        chk({tag, "_last"}, m_last, n == len - 1);
                        chk({tag, "_raddr_tx"}, m_raddr, (n < nregs) ? n : 0);
                        if (fresh) chk({tag, "_latency"}, k, hs_k + ((n < nregs) ? 2 : 1));
                    end
                    fresh = 1'b0;
                    if (reset_at == n) begin
                        #2 reset = 1'b1;
                        #1;
                        chk({tag, "_rst_valid"}, m_valid, 0);
                        chk({tag, "_rst_busy"}, m_busy, 0);
                        chk({tag, "_rst_done"}, m_done, 0);
                        chk({tag, "_rst_last"}, m_last, 0);
                        chk({tag, "_rst_data"}, m_data, 0);
                        chk({tag, "_rst_raddr"}, m_raddr, 0);
                        @(negedge clock);
                        reset     = 1'b0;
                        out_ready = 1'b1;
                        return;
                    end
                    if (restart_at == n && !restarted) begin
                        start     = !sel4;
                        start4    = sel4;
                        restarted = 1'b1;
                    end
                    if (stall_at == n && stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                        in_stall  = 1'b1;
                    end else begin
                        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                    end
                    if (out_ready) begin
                        last_word = m_data;
                        n++;
                        hs_k  = k;
                        fresh = 1'b1;
                    end
                end else begin
                    chk({tag, "_raddr_rd"}, m_raddr, n);
                    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                end
            end
            if (!finished) @(negedge clock);
        end
        chk({tag, "_timeout"}, finished, 1);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        start4    = 1'b0;
        out_ready = 1'b1;
        last_word = '0;
        for (int i = 0; i < 32; i++) begin
            rf[i]  = 32'(i);
            rf4[i] = '0;
        end
        rf4[0] = 32'd0;
        rf4[1] = 32'd5;
        rf4[2] = 32'd9;
        rf4[3] = 32'hFFFF_FFFF;

        repeat (2) @(negedge clock);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_last", out_last, 0);
        chk("reset_data", out_data, 0);
        chk("reset_raddr", rf_raddr, 0);
        chk("reset4_valid", out_valid4, 0);
        chk("reset4_data", out_data4, 0);
        reset = 1'b0;

        run_dump("seq", -1, 0, -1, -1, 1'b0, CSUM_ON ? 65 : 64);
`ifdef REGDUMP_CHECKSUM_EN
        chk("seq_csum_word", last_word, 32'h0000_01F0);
`endif
        run_dump("stall", 7, 5, -1, -1, 1'b0, -1);
        run_dump("restart", -1, 0, 3, -1, 1'b0, CSUM_ON ? 65 : 64);
        run_dump("rst_abort", -1, 0, -1, 10, 1'b0, -1);
        run_dump("after_rst", -1, 0, -1, -1, 1'b0, CSUM_ON ? 65 : 64);

        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        run_dump("rand", -1, 0, -1, -1, 1'b1, -1);

        sel4 = 1'b1;
        run_dump("n4", -1, 0, -1, -1, 1'b0, CSUM_ON ? 9 : 8);
`ifdef REGDUMP_CHECKSUM_EN
        chk("n4_csum_wrap", last_word, 32'h0000_000D);
`endif
        for (int i = 0; i < 4; i++) rf4[i] = $urandom;
        run_dump("n4_rand", -1, 0, -1, -1, 1'b1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
